sar_ctrl: RTL and testbench
===========================

Name: sar_ctrl

Overview:
- Synchronous SAR controller that drives the capacitor DAC and comparator in the SAR-ADC model.
- Sequences track/sample, then performs one comparator decision per clock.
- Switches one DAC capacitor per decision using the monotonic (vcm-based) scheme: 7 capacitors yield 8 bits.
- Returns the final binary code with a one-cycle valid strobe. Sits between the comparator output and the `dac_data_h`/`dac_data_l` inputs of the cap DAC.

Parameters:
- ADC_BITS, 8, resolution; DAC control width is ADC_BITS-1.
- SAMPLE_CYCLES, 2, track-phase length in clocks (legal range ≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; level sampled each edge.
- comp_out  input  1  comparator decision; 1 = DAC output above vcm.
- sample  output  1  track-switch enable for the input sampler.
- comp_en  output  1  comparator clock enable; high during decision cycles.
- dac_data_h  output  [1:ADC_BITS-1]  per-cap high control; index 1 = MSB cap.
- dac_data_l  output  [1:ADC_BITS-1]  per-cap low control.
- dout  output  [ADC_BITS-1:0]  conversion result, offset binary.
- dout_valid  output  1  one-cycle strobe when dout updates.
- busy  output  1  high in SAMPLE and CONVERT.

Behaviour:
- DAC encoding per cap i, as (h,l):
  - 00 = vcm
  - 10 = vrefp
  - 01 = vrefn
  - 11 is never driven.
- Reset values: state IDLE; sample, comp_en, busy, dout_valid = 0; dac_data_h and dac_data_l all 0; dout = 0; bit counter = 0.
- States:
  - IDLE:
    - Outputs hold: DAC codes and dout keep their last values.
    - If start=1, go to SAMPLE.
  - SAMPLE:
    - sample=1, busy=1.
    - All DAC codes forced to 00 on entry edge.
    - Stays exactly SAMPLE_CYCLES cycles, then goes to CONVERT.
    - start is ignored.
  - CONVERT:
    - busy=1, comp_en=1, sample=0.
    - Counter k runs 0..ADC_BITS-1. At each edge, comp_out is registered as result bit ADC_BITS-1-k.
    - If k<ADC_BITS-1, cap k+1 is switched on the same edge: comp_out=1 gives (h,l)=01 (vrefn); comp_out=0 gives 10 (vrefp).
    - The final decision (k=ADC_BITS-1) switches no cap.
    - Each cap is switched at most once per conversion and never returns to vcm before the next SAMPLE.
    - The edge registering the last decision copies the assembled bits to dout and moves to DONE.
  - DONE:
    - dout_valid=1 for exactly one cycle.
    - If start=1, go directly to SAMPLE (back-to-back conversions); otherwise go to IDLE.
- Latency: dout_valid is high in the cycle following the edge SAMPLE_CYCLES+ADC_BITS edges after the edge accepting start. With defaults this is 10 edges; conversion period is 11 cycles with start held high.
- dout and DAC codes stay stable from DONE until the next SAMPLE entry (DAC) or the next DONE (dout).
- comp_out is only used in CONVERT; X or toggling outside CONVERT has no effect.
- Reset asserted in any state, including mid-CONVERT, returns all outputs to reset values on that edge. The partial result is discarded and no dout_valid is issued.
- start asserted while busy is ignored, not queued.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 → all outputs 0, state stays IDLE for 20 cycles, dout_valid never high.
- Directed code: start pulse, comp_out sequence 1,0,1,1,0,0,1,0 over decision cycles → dout=8'hB2; final dac_data_h[1:7]=0100110, dac_data_l[1:7]=1011001; dout_valid high one cycle, exactly 10 edges after the start edge.
- Extremes: all-1 decisions → dout=8'hFF, h=0000000, l=1111111. All-0 decisions → dout=8'h00, h=1111111, l=0000000. Never h&l=1 on any bit in any cycle.
- Closed loop with cap_dac (PAR_CAP=0, vrefp=1.0, vrefn=0, vcm=0.5, comparator vo>vcm): vi=0.75 → dout=8'hC0±1; vi=0.25 → 8'h40±1; vi=0.5-ε → 8'h7F.
- start held high continuously → dout_valid every 11 cycles. start pulses during SAMPLE/CONVERT ignored, with no extra conversions and busy pattern unchanged.
- rst asserted at decision k=4 → next cycle all outputs 0, no dout_valid. A following start produces a correct full conversion with the prior dout overwritten.

Source files
------------

// File: rtl/sar_ctrl.sv
// -----------------------------------------------------------------------------
// sar_ctrl
// Successive-approximation controller for a monotonic (vcm-based) SAR ADC.
// Runs a track phase, then makes one comparator decision per clock. Each
// decision but the last switches one DAC capacitor from vcm to vrefn
// (comparator high) or to vrefp (comparator low). ADC_BITS-1 capacitors
// therefore resolve ADC_BITS bits.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       conversion request (level, sampled each edge)
//   comp_out    comparator decision, 1 = DAC node above vcm
//   sample      track-switch enable (high in SAMPLE)
//   comp_en     comparator enable (high in decision cycles)
//   dac_data_h  per-cap high control, index 1 = MSB cap
//   dac_data_l  per-cap low control
//   dout        conversion result, offset binary
//   dout_valid  one-cycle strobe when dout updates
//   busy        high in SAMPLE and CONVERT
// -----------------------------------------------------------------------------
module sar_ctrl #(
  parameter int ADC_BITS      = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comp_out,
  output logic                sample,
  output logic                comp_en,
  output logic [1:ADC_BITS-1] dac_data_h,
  output logic [1:ADC_BITS-1] dac_data_l,
  output logic [ADC_BITS-1:0] dout,
  output logic                dout_valid,
  output logic                busy
);

  // One counter serves both the track phase and the decision index.
  localparam int CNT_MAX = (ADC_BITS > SAMPLE_CYCLES) ? ADC_BITS : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DECIDE_LAST  = CNT_W'(ADC_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADC_BITS-1:0]   result_q, result_d;
  logic [ADC_BITS-1:0]   dout_q, dout_d;
  logic [1:ADC_BITS-1]   dac_h_q, dac_h_d;
  logic [1:ADC_BITS-1]   dac_l_q, dac_l_d;
  logic                  sample_q, sample_d;
  logic                  comp_en_q, comp_en_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dout_d   = dout_q;
    dac_h_d  = dac_h_q;
    dac_l_d  = dac_l_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Entering SAMPLE: every cap back to vcm, old partial bits cleared.
          state_d  = SAMPLE;
          cnt_d    = '0;
          result_d = '0;
          dac_h_d  = '0;
          dac_l_d  = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      CONVERT: begin
        // Decision k lands in result bit ADC_BITS-1-k (constant-index loop
        // keeps the selects at their natural widths).
        for (int i = 0; i < ADC_BITS; i++) begin
          if (cnt_q == CNT_W'(ADC_BITS - 1 - i)) begin
            result_d[i] = comp_out;
          end
        end
        // Decision k switches cap k+1; a high comparator pulls the node down.
        for (int i = 1; i < ADC_BITS; i++) begin
          if (cnt_q == CNT_W'(i - 1)) begin
            dac_h_d[i] = ~comp_out;
            dac_l_d[i] = comp_out;
          end
        end
        if (cnt_q == DECIDE_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          dout_d  = result_d;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sample_d  = (state_d == SAMPLE);
    comp_en_d = (state_d == CONVERT);
    busy_d    = (state_d == SAMPLE) || (state_d == CONVERT);
    valid_d   = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      dout_q    <= '0;
      dac_h_q   <= '0;
      dac_l_q   <= '0;
      sample_q  <= 1'b0;
      comp_en_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      dout_q    <= dout_d;
      dac_h_q   <= dac_h_d;
      dac_l_q   <= dac_l_d;
      sample_q  <= sample_d;
      comp_en_q <= comp_en_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign sample     = sample_q;
  assign comp_en    = comp_en_q;
  assign busy       = busy_q;
  assign dout_valid = valid_q;
  assign dout       = dout_q;
  assign dac_data_h = dac_h_q;
  assign dac_data_l = dac_l_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_ctrl
// Bench for sar_ctrl. The comparator is a closed-loop charge model of the
// monotonic cap DAC: the sampled input is (2x+1)/512 of vref (half an LSB
// above code x, so no decision ever ties), each cap i moves the node by
// 2^(8-i)/512 towards the rail it is switched to, and comp_out = node > vcm.
// The expected code for input x is therefore simply x, and the final cap
// pattern follows from the result bits.
// -----------------------------------------------------------------------------
module tb_sar_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       comp_out;
  logic       sample;
  logic       comp_en;
  logic [1:7] dac_data_h;
  logic [1:7] dac_data_l;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int dv_cnt   = 0;

  logic [7:0] x_r     = 8'd0;
  logic       noise_r = 1'b0;
  logic       mon_en  = 1'b0;

  sar_ctrl #(.ADC_BITS(8), .SAMPLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .comp_out   (comp_out),
    .sample     (sample),
    .comp_en    (comp_en),
    .dac_data_h (dac_data_h),
    .dac_data_l (dac_data_l),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Charge-redistribution model in units of vref/512; vcm = 256.
  function automatic logic cmp_model(input logic [7:0] x, input logic [1:7] h,
                                     input logic [1:7] l);
    int node;
    node = 2 * int'(x) + 1;
    for (int i = 1; i <= 7; i++) begin
      if (h[i]) node = node + (1 << (8 - i));
      if (l[i]) node = node - (1 << (8 - i));
    end
    return node > 256;
  endfunction

  // Outside decision cycles the comparator output is random noise.
  assign comp_out = comp_en ? cmp_model(x_r, dac_data_h, dac_data_l) : noise_r;

  always @(negedge clk) noise_r <= 1'($urandom_range(0, 1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Continuous monitor: no cap ever driven 11, and count valid strobes.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("no_h_and_l", 32'(dac_data_h & dac_data_l), 32'd0);
      if (dout_valid) dv_cnt++;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sample"}, 32'(sample), 32'd0);
    chk({tag, "_comp_en"}, 32'(comp_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_dac_h"}, 32'(dac_data_h), 32'd0);
    chk({tag, "_dac_l"}, 32'(dac_data_l), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
  endtask

  // One conversion from IDLE; reports result, final caps, and edges from
  // the accepting edge to the edge after which dout_valid is seen.
  task automatic run_conv(input logic [7:0] x, output logic [7:0] d,
                          output logic [1:7] h, output logic [1:7] l,
                          output int edges);
    x_r = x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 99;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dout_valid) begin
        edges = n;
        break;
      end
      @(posedge clk);
    end
    d = dout;
    h = dac_data_h;
    l = dac_data_l;
    @(negedge clk);
    chk("valid_one_cycle", 32'(dout_valid), 32'd0);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] exp_dout;
    logic [1:7] exp_h;
    logic [1:7] exp_l;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] d;
    logic [1:7] h, l, eh, el;
    int edges;
    int dv_before;
    int last_dv;
    int cyc;
    int pulses;

    rst   = 1'b1;
    start = 1'b0;

    vecs[0] = '{8'hB2, 8'hB2, 7'b0100110, 7'b1011001};
    vecs[1] = '{8'hFF, 8'hFF, 7'b0000000, 7'b1111111};
    vecs[2] = '{8'h00, 8'h00, 7'b1111111, 7'b0000000};
    vecs[3] = '{8'hC0, 8'hC0, 7'b0011111, 7'b1100000};
    vecs[4] = '{8'h40, 8'h40, 7'b1011111, 7'b0100000};
    vecs[5] = '{8'h7F, 8'h7F, 7'b1000000, 7'b0111111};

    // Reset, then idle for 20 cycles with no activity.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst    = 1'b0;
    mon_en = 1'b1;
    dv_before = dv_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || sample !== 1'b0) chk("idle_quiet", 32'(busy | sample), 32'd0);
    end
    chk("idle_no_valid", 32'(dv_cnt - dv_before), 32'd0);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      run_conv(vecs[v].x, d, h, l, edges);
      chk($sformatf("vec%0d_dout", v), 32'(d), 32'(vecs[v].exp_dout));
      chk($sformatf("vec%0d_dac_h", v), 32'(h), 32'(vecs[v].exp_h));
      chk($sformatf("vec%0d_dac_l", v), 32'(l), 32'(vecs[v].exp_l));
      chk($sformatf("vec%0d_latency", v), 32'(edges), 32'd10);
    end

    // Randomized inputs against the reference model.
    for (int r = 0; r < 20; r++) begin
      logic [7:0] xr;
      xr = 8'($urandom_range(0, 255));
      run_conv(xr, d, h, l, edges);
      for (int i = 1; i <= 7; i++) begin
        el[i] = xr[8 - i];
        eh[i] = ~xr[8 - i];
      end
      chk($sformatf("rand%0d_dout", r), 32'(d), 32'(xr));
      chk($sformatf("rand%0d_dac_h", r), 32'(h), 32'(eh));
      chk($sformatf("rand%0d_dac_l", r), 32'(l), 32'(el));
      chk($sformatf("rand%0d_latency", r), 32'(edges), 32'd10);
    end

    // start held high: back-to-back conversions every 11 cycles.
    x_r = 8'h96;
    @(negedge clk);
    start   = 1'b1;
    cyc     = 0;
    last_dv = -1;
    pulses  = 0;
    for (int n = 0; n < 80 && pulses < 4; n++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (dout_valid) begin
        chk("b2b_dout", 32'(dout), 32'h96);
        if (last_dv >= 0) chk("b2b_period", 32'(cyc - last_dv), 32'd11);
        last_dv = cyc;
        pulses++;
        if (pulses == 4) start = 1'b0;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd4);
    repeat (3) @(negedge clk);
    chk("b2b_stops", 32'(busy), 32'd0);

    // start toggled while busy: ignored, one conversion, busy pattern intact.
    x_r = 8'h3D;
    dv_before = dv_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 10; e++) begin
      #1 start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("ignore_busy_e%0d", e), 32'(busy), 32'd1);
      @(posedge clk);
    end
    #1 start = 1'b0;
    @(negedge clk);
    chk("ignore_valid", 32'(dout_valid), 32'd1);
    chk("ignore_dout", 32'(dout), 32'h3D);
    chk("ignore_busy_done", 32'(busy), 32'd0);
    repeat (15) @(negedge clk);
    chk("ignore_one_conv", 32'(dv_cnt - dv_before), 32'd1);
    chk("ignore_idle", 32'(busy), 32'd0);

    // Reset in the cycle of decision k=4: everything clears, no strobe.
    x_r = 8'hA7;
    dv_before = dv_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst_no_valid", 32'(dv_cnt - dv_before), 32'd0);
    run_conv(8'h5A, d, h, l, edges);
    chk("after_rst_dout", 32'(d), 32'h5A);
    chk("after_rst_latency", 32'(edges), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
